// File: rtl/uart_bridge_router.sv
// N-channel UART byte router: edge-captured sources, round-robin arbiter, per-destination FIFOs and TX FSMs.
// Optional BRIDGE_STATS_EN adds saturating routed/dropped byte counters.
module uart_bridge_router #(
  parameter int N_CH         = 2,
  parameter int W            = 8,
  parameter int DEPTH        = 8,
  parameter int DROP_ON_FULL = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_CH-1:0]        rx_valid,
  input  logic [N_CH*W-1:0]      rx_data,
  input  logic [N_CH*N_CH-1:0]   route_mask,
  input  logic                   inj_valid,
  input  logic [W-1:0]           inj_data,
  input  logic [N_CH-1:0]        inj_mask,
  input  logic [N_CH-1:0]        tx_busy,
  output logic [N_CH-1:0]        tx_en,
  output logic [N_CH*W-1:0]      tx_data,
  output logic                   mon_valid,
  output logic [W-1:0]           mon_data,
  output logic [3:0]             mon_src,
`ifdef BRIDGE_STATS_EN
  output logic [N_CH:0]          overrun,
  output logic [15:0]            stat_routed,
  output logic [15:0]            stat_dropped
`else
  output logic [N_CH:0]          overrun
`endif
);
  localparam int NR = N_CH + 1;
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} tx_state_t;

  logic [NR-1:0]                src_valid, prev, pend, elig, gnt_oh;
  logic [NR-1:0][W-1:0]         src_data, hold_data;
  logic [NR-1:0][N_CH-1:0]      src_mask;
  logic [N_CH-1:0]              full, push, drop;
  logic                         gnt;
  logic [3:0]                   gnt_src, rr_ptr;
  logic [W-1:0]                 gnt_data;
  logic [N_CH-1:0]              gnt_mask;

  // Injection source sits at index N_CH after the UART channels.
  always_comb begin
    src_valid      = {inj_valid, rx_valid};
    src_data       = '0;
    src_mask       = '0;
    src_data[N_CH] = inj_data;
    src_mask[N_CH] = inj_mask;
    for (int s = 0; s < N_CH; s++) begin
      src_data[s] = rx_data[s*W +: W];
      src_mask[s] = route_mask[s*N_CH +: N_CH];
    end
  end

  always_comb begin
    elig = '0;
    for (int s = 0; s < NR; s++)
      elig[s] = pend[s] && (DROP_ON_FULL != 0 || (src_mask[s] & full) == '0);
  end

  // Round robin as two passes: sources above the last grant first, then wrap to 0.
  always_comb begin
    gnt      = 1'b0;
    gnt_src  = '0;
    gnt_oh   = '0;
    gnt_data = '0;
    gnt_mask = '0;
    for (int s = 0; s < NR; s++)
      if (!gnt && elig[s] && s > int'(rr_ptr)) begin
        gnt = 1'b1; gnt_src = 4'(s); gnt_oh[s] = 1'b1;
        gnt_data = hold_data[s]; gnt_mask = src_mask[s];
      end
    for (int s = 0; s < NR; s++)
      if (!gnt && elig[s]) begin
        gnt = 1'b1; gnt_src = 4'(s); gnt_oh[s] = 1'b1;
        gnt_data = hold_data[s]; gnt_mask = src_mask[s];
      end
  end

  always_comb begin
    push = gnt ? (gnt_mask & ~full) : '0;
    drop = gnt ? (gnt_mask & full)  : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev      <= '0;
      pend      <= '0;
      hold_data <= '0;
      overrun   <= '0;
      rr_ptr    <= 4'(N_CH);
      mon_valid <= 1'b0;
      mon_data  <= '0;
      mon_src   <= '0;
    end else begin
      prev      <= src_valid;
      mon_valid <= gnt;
      if (gnt) begin
        mon_data <= gnt_data;
        mon_src  <= gnt_src;
        rr_ptr   <= gnt_src;
      end
      // A fresh edge wins over a same-cycle grant; it only overruns an unconsumed byte.
      for (int s = 0; s < NR; s++) begin
        if (src_valid[s] && !prev[s]) begin
          hold_data[s] <= src_data[s];
          pend[s]      <= 1'b1;
          if (pend[s] && !gnt_oh[s]) overrun[s] <= 1'b1;
        end else if (gnt_oh[s]) begin
          pend[s] <= 1'b0;
        end
      end
    end
  end

  for (genvar d = 0; d < N_CH; d++) begin : g_ch
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt;
    tx_state_t     state, state_n;
    logic          pop, en_q;
    logic [W-1:0]  dat_q;

    assign full[d]           = (cnt == (AW+1)'(DEPTH));
    assign tx_en[d]          = en_q;
    assign tx_data[d*W +: W] = dat_q;

    always_comb begin
      state_n = state;
      pop     = 1'b0;
      case (state)
        IDLE:      if (cnt != '0) begin pop = 1'b1; state_n = WAIT_BUSY; end
        WAIT_BUSY: if (tx_busy[d])  state_n = WAIT_DONE;
        WAIT_DONE: if (!tx_busy[d]) state_n = IDLE;
        default:   state_n = IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state  <= IDLE;
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
        en_q   <= 1'b0;
        dat_q  <= '0;
      end else begin
        state <= state_n;
        en_q  <= pop;
        if (pop) begin
          dat_q  <= mem[rd_ptr];
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (push[d]) begin
          mem[wr_ptr] <= gnt_data;
          wr_ptr      <= wr_ptr + 1'b1;
        end
        cnt <= cnt + (AW+1)'(push[d]) - (AW+1)'(pop);
      end
    end
  end

`ifdef BRIDGE_STATS_EN
  logic [4:0]  drop_n;
  logic [16:0] drop_sum;

  always_comb begin
    drop_n = '0;
    for (int d = 0; d < N_CH; d++) drop_n = drop_n + 5'(drop[d]);
  end
  assign drop_sum = {1'b0, stat_dropped} + 17'(drop_n);

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_routed  <= '0;
      stat_dropped <= '0;
    end else begin
      if (gnt && stat_routed != 16'hFFFF) stat_routed <= stat_routed + 16'd1;
      stat_dropped <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end
`endif
endmodule

// File: tb/tb_uart_bridge_router.sv
// Directed bench for uart_bridge_router: one drop-mode and one stall-mode instance share stimulus.
module tb_uart_bridge_router;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  rx_valid;
  logic [15:0] rx_data;
  logic [3:0]  route_mask;
  logic        inj_valid;
  logic [7:0]  inj_data;
  logic [1:0]  inj_mask;
  logic [1:0]  hold;

  logic [1:0]  tx_busy_a, tx_busy_b, tx_en_a, tx_en_b;
  logic [15:0] tx_data_a, tx_data_b;
  logic        mon_valid_a, mon_valid_b;
  logic [7:0]  mon_data_a, mon_data_b;
  logic [3:0]  mon_src_a, mon_src_b;
  logic [2:0]  overrun_a, overrun_b;
`ifdef BRIDGE_STATS_EN
  logic [15:0] stat_routed_a, stat_dropped_a, stat_routed_b, stat_dropped_b;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_bridge_router #(.N_CH(2), .W(8), .DEPTH(8), .DROP_ON_FULL(1)) u_drop (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .route_mask(route_mask), .inj_valid(inj_valid), .inj_data(inj_data),
    .inj_mask(inj_mask), .tx_busy(tx_busy_a), .tx_en(tx_en_a), .tx_data(tx_data_a),
    .mon_valid(mon_valid_a), .mon_data(mon_data_a), .mon_src(mon_src_a),
`ifdef BRIDGE_STATS_EN
    .stat_routed(stat_routed_a), .stat_dropped(stat_dropped_a),
`endif
    .overrun(overrun_a));

  uart_bridge_router #(.N_CH(2), .W(8), .DEPTH(8), .DROP_ON_FULL(0)) u_stall (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .route_mask(route_mask), .inj_valid(inj_valid), .inj_data(inj_data),
    .inj_mask(inj_mask), .tx_busy(tx_busy_b), .tx_en(tx_en_b), .tx_data(tx_data_b),
    .mon_valid(mon_valid_b), .mon_data(mon_data_b), .mon_src(mon_src_b),
`ifdef BRIDGE_STATS_EN
    .stat_routed(stat_routed_b), .stat_dropped(stat_dropped_b),
`endif
    .overrun(overrun_b));

  // Transmitter model: busy for 3 cycles after each start, or forced by hold.
  logic [1:0] bc_a [2] = '{2'd0, 2'd0};
  logic [1:0] bc_b [2] = '{2'd0, 2'd0};
  always @(posedge clk)
    for (int d = 0; d < 2; d++) begin
      if (tx_en_a[d]) bc_a[d] <= 2'd3; else if (bc_a[d] != 2'd0) bc_a[d] <= bc_a[d] - 2'd1;
      if (tx_en_b[d]) bc_b[d] <= 2'd3; else if (bc_b[d] != 2'd0) bc_b[d] <= bc_b[d] - 2'd1;
    end
  assign tx_busy_a = hold | {bc_a[1] != 2'd0, bc_a[0] != 2'd0};
  assign tx_busy_b = hold | {bc_b[1] != 2'd0, bc_b[0] != 2'd0};

  // Record every transmitted byte per channel.
  logic [7:0] rec_a [2][64];
  logic [7:0] rec_b [2][64];
  int n_a [2] = '{0, 0};
  int n_b [2] = '{0, 0};
  always @(negedge clk)
    for (int d = 0; d < 2; d++) begin
      if (tx_en_a[d] && n_a[d] < 64) begin rec_a[d][n_a[d]] = tx_data_a[d*8 +: 8]; n_a[d]++; end
      if (tx_en_b[d] && n_b[d] < 64) begin rec_b[d][n_b[d]] = tx_data_b[d*8 +: 8]; n_b[d]++; end
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rx_valid = '0; inj_valid = 1'b0; hold = '0;
    reset = 1'b1; tick(2);
    reset = 1'b0;
  endtask

  task automatic send0(input logic [7:0] b);
    rx_data[7:0] = b; rx_valid[0] = 1'b1; tick(1);
    rx_valid[0] = 1'b0; tick(1);
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_tx_en"},   32'(tx_en_a),     0);
    chk({pfx, "_tx_data"}, 32'(tx_data_a),   0);
    chk({pfx, "_mon_v"},   32'(mon_valid_a), 0);
    chk({pfx, "_mon_d"},   32'(mon_data_a),  0);
    chk({pfx, "_mon_s"},   32'(mon_src_a),   0);
    chk({pfx, "_ovr"},     32'(overrun_a),   0);
  endtask

  int b0, b1;
  logic [7:0] e2 [3] = '{8'hA0, 8'hB1, 8'hC2};

  initial begin
    reset = 1'b1; rx_valid = '0; rx_data = '0; route_mask = '0;
    inj_valid = 1'b0; inj_data = '0; inj_mask = '0; hold = '0;
    tick(3);
    chk_zero("rst");
    reset = 1'b0;

    // Test 1: src0 -> ch1, src1 -> ch0; single byte latency.
    route_mask = 4'b0110;
    tick(1);
    chk("t1_idle_en", 32'(tx_en_a), 0);
    rx_data[7:0] = 8'h41; rx_valid[0] = 1'b1; tick(1);
    rx_valid[0] = 1'b0;
    chk("t1_mon_early", 32'(mon_valid_a), 0);
    tick(1);
    chk("t1_mon_v", 32'(mon_valid_a), 1);
    chk("t1_mon_s", 32'(mon_src_a), 0);
    chk("t1_mon_d", 32'(mon_data_a), 'h41);
    chk("t1_en_early", 32'(tx_en_a), 0);
    tick(1);
    chk("t1_tx_en", 32'(tx_en_a), 'b10);
    chk("t1_tx_data", 32'(tx_data_a[15:8]), 'h41);
    tick(1);
    chk("t1_tx_en_off", 32'(tx_en_a), 0);
    chk("t1_mon_hold", 32'(mon_data_a), 'h41);
    tick(20);
    chk("t1_no_ch0", 32'(n_a[0]), 0);
    chk("t1_ch1_cnt", 32'(n_a[1]), 1);

    // Test 2: three simultaneous sources broadcast to both channels.
    do_reset();
    route_mask = 4'b1111; inj_mask = 2'b11;
    b0 = n_a[0]; b1 = n_a[1];
    rx_data = 16'hB1A0; inj_data = 8'hC2; rx_valid = 2'b11; inj_valid = 1'b1;
    tick(1);
    rx_valid = '0; inj_valid = 1'b0;
    tick(1);
    for (int i = 0; i < 3; i++) begin
      chk("t2_mon_v", 32'(mon_valid_a), 1);
      chk("t2_mon_s", 32'(mon_src_a), 32'(i));
      chk("t2_mon_d", 32'(mon_data_a), 32'(e2[i]));
      tick(1);
    end
    chk("t2_mon_off", 32'(mon_valid_a), 0);
    tick(40);
    chk("t2_cnt0", 32'(n_a[0] - b0), 3);
    chk("t2_cnt1", 32'(n_a[1] - b1), 3);
    for (int i = 0; i < 3; i++) begin
      chk("t2_ch0", 32'(rec_a[0][b0 + i]), 32'(e2[i]));
      chk("t2_ch1", 32'(rec_a[1][b1 + i]), 32'(e2[i]));
    end

    // Test 3: drop mode. First byte goes straight to the busy transmitter,
    // the next 8 fill the FIFO and the 10th is dropped.
    do_reset();
    route_mask = 4'b0010; hold = 2'b10;
    b1 = n_a[1];
    for (int i = 0; i < 10; i++) send0(8'h10 + 8'(i));
    tick(4);
    chk("t3_inflight", 32'(n_a[1] - b1), 1);
`ifdef BRIDGE_STATS_EN
    chk("t3_dropped", 32'(stat_dropped_a), 1);
    chk("t3_routed",  32'(stat_routed_a), 10);
`endif
    hold = '0;
    tick(80);
    chk("t3_cnt", 32'(n_a[1] - b1), 9);
    for (int i = 0; i < 9; i++) chk("t3_byte", 32'(rec_a[1][b1 + i]), 32'('h10 + i));

    // Test 4: stall mode. 0x29 waits pending; 0x2A overruns and replaces it.
    do_reset();
    route_mask = 4'b0010; hold = 2'b10;
    b1 = n_b[1];
    for (int i = 0; i < 10; i++) send0(8'h20 + 8'(i));
    tick(2);
    chk("t4_no_ovr", 32'(overrun_b), 0);
    send0(8'h2A);
    chk("t4_ovr", 32'(overrun_b), 'b001);
    chk("t4_drop_no_ovr", 32'(overrun_a), 0);
    hold = '0;
    tick(100);
    chk("t4_cnt", 32'(n_b[1] - b1), 10);
    for (int i = 0; i < 9; i++) chk("t4_byte", 32'(rec_b[1][b1 + i]), 32'('h20 + i));
    chk("t4_last", 32'(rec_b[1][b1 + 9]), 'h2A);

    // Test 5: reset while in WAIT_DONE with 3 queued bytes.
    do_reset();
    route_mask = 4'b0010; hold = 2'b10;
    b0 = n_a[0]; b1 = n_a[1];
    for (int i = 0; i < 4; i++) send0(8'h30 + 8'(i));
    tick(3);
    chk("t5_inflight", 32'(n_a[1] - b1), 1);
    reset = 1'b1; tick(1);
    chk_zero("t5_rst");
    reset = 1'b0; hold = '0;
    tick(30);
    chk("t5_quiet1", 32'(n_a[1] - b1), 1);
    chk("t5_quiet0", 32'(n_a[0] - b0), 0);
    send0(8'h34);
    tick(10);
    chk("t5_new_cnt", 32'(n_a[1] - b1), 2);
    chk("t5_new_byte", 32'(rec_a[1][b1 + 1]), 'h34);

    // Test 6: empty destination set is monitored but never transmitted.
    do_reset();
    route_mask = 4'b0000;
    b0 = n_a[0]; b1 = n_a[1];
    rx_data[7:0] = 8'h7E; rx_valid[0] = 1'b1; tick(1);
    rx_valid[0] = 1'b0; tick(1);
    chk("t6_mon_v", 32'(mon_valid_a), 1);
    chk("t6_mon_d", 32'(mon_data_a), 'h7E);
    chk("t6_mon_s", 32'(mon_src_a), 0);
    tick(10);
    chk("t6_no_tx", 32'((n_a[0] - b0) + (n_a[1] - b1)), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
